// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module : fwd_pkg
// Brief  : Shared types and helpers for the forwarding / load-use hazard unit.
// Rev    : 1.0  initial release
// ============================================================================
package fwd_pkg;

    // Tracked rd field is stored zero-extended to this width; REG_AW must not exceed it.
    localparam int FWD_MAX_AW = 8;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [FWD_MAX_AW-1:0] rd;
        logic                  is_load;
    } fwd_entry_t;

    function automatic int fwd_sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [31:0] fwd_sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_unit_src_match.sv
`default_nettype none
// ============================================================================
// Module : fwd_src_match
// Brief  : Youngest-producer select and load-use hazard flag for one operand.
// Rev    : 1.0  initial release
// ============================================================================
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 4,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SELW      = fwd_sel_width(FWD_DEPTH)
) (
    input  fwd_entry_t [FWD_DEPTH-1:0] entries,
    input  logic [REG_AW-1:0]          src,
    input  logic                       src_used,
    input  logic                       id_valid,
    output logic [SELW-1:0]            fwd_sel,
    output logic                       hazard
);

    logic [FWD_MAX_AW-1:0] w_src;
    logic [SELW-1:0]       w_sel;
    logic                  w_sel_load;

    assign w_src = FWD_MAX_AW'(src);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        w_sel      = SELW'(FWD_SEL_RF);
        w_sel_load = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (entries[k-1].valid && (entries[k-1].rd == w_src) &&
                (src != '0) && src_used) begin
                w_sel      = SELW'(k);
                w_sel_load = entries[k-1].is_load;
            end
        end
    end

    assign hazard  = id_valid && w_sel_load && (w_sel != '0) && (int'(w_sel) <= LOAD_LAT);
    assign fwd_sel = hazard ? SELW'(FWD_SEL_RF) : w_sel;

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_unit
// Brief  : Tracks in-flight writers, selects operand forwarding and stalls on
//          load-use. Optional statistics counters under FWD_HAZARD_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 4,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SELW      = fwd_sel_width(FWD_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    output logic                      stall,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      busy
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]               stat_stall_cyc,
    output logic [31:0]               stat_fwd_cnt,
    output logic [31:0]               stat_ld_hazards
`endif
);

    fwd_entry_t [FWD_DEPTH-1:0] entries_q, entries_d;
    logic [NUM_SRC-1:0]         w_hazard;
    logic [NUM_SRC*SELW-1:0]    w_sel;
    logic                       w_issue;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_src_match #(
                .REG_AW    (REG_AW),
                .FWD_DEPTH (FWD_DEPTH),
                .LOAD_LAT  (LOAD_LAT),
                .SELW      (SELW)
            ) u_match (
                .entries  (entries_q),
                .src      (id_src[i*REG_AW +: REG_AW]),
                .src_used (id_src_used[i]),
                .id_valid (id_valid),
                .fwd_sel  (w_sel[i*SELW +: SELW]),
                .hazard   (w_hazard[i])
            );
        end
    endgenerate

    assign stall   = ~flush & (|w_hazard);
    assign fwd_sel = flush ? '0 : w_sel;
    assign w_issue = id_valid & ~stall & ~flush;

    // A flush empties every stage, including the slot the ID instruction would take.
    always_comb begin
        entries_d = '0;
        if (!flush) begin
            for (int k = 1; k < FWD_DEPTH; k++) begin
                entries_d[k] = entries_q[k-1];
            end
            if (w_issue && id_we && (id_rd != '0)) begin
                entries_d[0].valid   = 1'b1;
                entries_d[0].rd      = FWD_MAX_AW'(id_rd);
                entries_d[0].is_load = id_is_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            busy = busy | entries_q[k].valid;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] ld_haz_q, ld_haz_d;
    logic        stall_prev_q;
    logic [31:0] w_fwd_ops;

    always_comb begin
        w_fwd_ops = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_issue && (fwd_sel[i*SELW +: SELW] != '0)) begin
                w_fwd_ops = w_fwd_ops + 32'd1;
            end
        end
        stall_cyc_d = fwd_sat_add(stall_cyc_q, {31'd0, stall});
        fwd_cnt_d   = fwd_sat_add(fwd_cnt_q, w_fwd_ops);
        ld_haz_d    = fwd_sat_add(ld_haz_q, {31'd0, stall & ~stall_prev_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cyc_q  <= '0;
            fwd_cnt_q    <= '0;
            ld_haz_q     <= '0;
            stall_prev_q <= 1'b0;
        end else begin
            stall_cyc_q  <= stall_cyc_d;
            fwd_cnt_q    <= fwd_cnt_d;
            ld_haz_q     <= ld_haz_d;
            stall_prev_q <= stall;
        end
    end

    assign stat_stall_cyc  = stall_cyc_q;
    assign stat_fwd_cnt    = fwd_cnt_q;
    assign stat_ld_hazards = ld_haz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fwd_hazard_unit
// Brief  : Self-checking bench for fwd_hazard_unit against a cycle-history model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int REG_AW    = 4;
    localparam int NUM_SRC   = 2;
    localparam int FWD_DEPTH = 2;
    localparam int LOAD_LAT  = 1;
    localparam int SELW      = 2;
    localparam int MAXC      = 4000;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      flush = 1'b0;
    logic                      id_valid = 1'b0;
    logic [REG_AW-1:0]         id_rd = '0;
    logic                      id_we = 1'b0;
    logic                      id_is_load = 1'b0;
    logic [NUM_SRC*REG_AW-1:0] id_src = '0;
    logic [NUM_SRC-1:0]        id_src_used = '0;
    logic                      stall;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      busy;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_stall_cyc, stat_fwd_cnt, stat_ld_hazards;
`endif

    fwd_hazard_unit #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH),
        .LOAD_LAT(LOAD_LAT), .SELW(SELW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .id_src(id_src), .id_src_used(id_src_used),
        .stall(stall), .fwd_sel(fwd_sel), .busy(busy)
`ifdef FWD_HAZARD_STATS_EN
        , .stat_stall_cyc(stat_stall_cyc), .stat_fwd_cnt(stat_fwd_cnt),
        .stat_ld_hazards(stat_ld_hazards)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Issue history indexed by cycle number; stage k at cycle c is what issued at c-k.
    bit h_wr [MAXC];
    int h_rd [MAXC];
    bit h_ld [MAXC];
    int cyc = 0;
    int last_kill = 0;

    int m_sel [NUM_SRC];
    bit m_stall, m_busy;
    longint m_sc = 0, m_fc = 0, m_lh = 0;
    bit m_prev_stall = 0;

    int d_sel [NUM_SRC];
    int d_stall, d_busy;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic bit alive(input int j);
        return rst_n && (j >= 0) && (j > last_kill) && h_wr[j];
    endfunction

    function automatic void model_eval();
        m_stall = 0;
        m_busy  = 0;
        for (int k = 1; k <= FWD_DEPTH; k++)
            if (alive(cyc - k)) m_busy = 1;
        for (int i = 0; i < NUM_SRC; i++) begin
            int src;
            bit found, hz;
            src = int'(id_src[i*REG_AW +: REG_AW]);
            m_sel[i] = 0;
            found = 0;
            hz = 0;
            if (id_src_used[i] && src != 0) begin
                for (int k = 1; k <= FWD_DEPTH; k++) begin
                    if (!found && alive(cyc - k) && h_rd[cyc - k] == src) begin
                        found = 1;
                        m_sel[i] = k;
                        hz = h_ld[cyc - k] && (k <= LOAD_LAT) && id_valid;
                    end
                end
            end
            if (flush) m_sel[i] = 0;
            else if (hz) begin
                m_sel[i] = 0;
                m_stall = 1;
            end
        end
    endfunction

    task automatic compare();
        if (!rst_n) begin
            m_sc = 0; m_fc = 0; m_lh = 0; m_prev_stall = 0;
        end
        model_eval();
        for (int i = 0; i < NUM_SRC; i++) begin
            d_sel[i] = int'(fwd_sel[i*SELW +: SELW]);
            chk($sformatf("fwd_sel[%0d]", i), d_sel[i], m_sel[i]);
        end
        d_stall = int'(stall);
        d_busy  = int'(busy);
        chk("stall", d_stall, m_stall);
        chk("busy", d_busy, m_busy);
`ifdef FWD_HAZARD_STATS_EN
        chk("stat_stall_cyc", stat_stall_cyc, m_sc);
        chk("stat_fwd_cnt", stat_fwd_cnt, m_fc);
        chk("stat_ld_hazards", stat_ld_hazards, m_lh);
`endif
    endtask

    task automatic record();
        bit issue;
        if (!rst_n) begin
            last_kill = cyc;
            h_wr[cyc] = 0;
        end else begin
            issue = id_valid && !m_stall && !flush;
            h_wr[cyc] = issue && id_we && (id_rd != 0);
            h_rd[cyc] = int'(id_rd);
            h_ld[cyc] = id_is_load;
            if (flush) last_kill = cyc;
            if (m_stall) m_sc = (m_sc == 64'hFFFF_FFFF) ? m_sc : m_sc + 1;
            if (m_stall && !m_prev_stall) m_lh = m_lh + 1;
            if (issue)
                for (int i = 0; i < NUM_SRC; i++)
                    if (m_sel[i] != 0) m_fc = m_fc + 1;
            m_prev_stall = m_stall;
        end
        cyc++;
    endtask

    task automatic drive(input bit v, input int rd, input bit we, input bit ld,
                         input int s0, input int s1, input bit [1:0] used, input bit fl);
        id_valid    = v;
        id_rd       = REG_AW'(rd);
        id_we       = we;
        id_is_load  = ld;
        id_src      = {REG_AW'(s1), REG_AW'(s0)};
        id_src_used = used;
        flush       = fl;
    endtask

    task automatic step(input bit v, input int rd, input bit we, input bit ld,
                        input int s0, input int s1, input bit [1:0] used, input bit fl);
        drive(v, rd, we, ld, s0, s1, used, fl);
        @(negedge clk);
        compare();
        record();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state with an instruction that would otherwise stall
        step(1, 3, 1, 1, 3, 3, 2'b11, 0);
        chk("reset_stall", d_stall, 0);
        chk("reset_busy", d_busy, 0);
        chk("reset_sel0", d_sel[0], 0);
        step(1, 3, 1, 1, 3, 3, 2'b11, 0);
        rst_n = 1'b1;
        idle(2);

        // Back-to-back ALU forwarding
        step(1, 3, 1, 0, 0, 0, 2'b00, 0);
        step(1, 0, 0, 0, 3, 0, 2'b01, 0);
        chk("b2b_sel0_stage1", d_sel[0], 1);
        chk("b2b_busy", d_busy, 1);
        step(1, 0, 0, 0, 0, 3, 2'b10, 0);
        chk("b2b_sel1_stage2", d_sel[1], 2);
        step(1, 0, 0, 0, 0, 3, 2'b10, 0);
        chk("b2b_sel1_gone", d_sel[1], 0);
        idle(2);

        // Youngest of two producers
        step(1, 5, 1, 0, 0, 0, 2'b00, 0);
        step(1, 5, 1, 0, 0, 0, 2'b00, 0);
        step(1, 0, 0, 0, 5, 0, 2'b01, 0);
        chk("dbl_sel0_youngest", d_sel[0], 1);
        idle(2);

        // Load-use: one stall cycle, then forward from stage 2
        step(1, 7, 1, 1, 0, 0, 2'b00, 0);
        step(1, 0, 0, 0, 0, 7, 2'b10, 0);
        chk("ld_stall", d_stall, 1);
        chk("ld_sel1_blocked", d_sel[1], 0);
        step(1, 0, 0, 0, 0, 7, 2'b10, 0);
        chk("ld_stall_cleared", d_stall, 0);
        chk("ld_sel1_stage2", d_sel[1], 2);
`ifdef FWD_HAZARD_STATS_EN
        step(0, 0, 0, 0, 0, 0, 2'b00, 0);
        chk("ld_stat_hazards", stat_ld_hazards, 1);
`endif
        idle(2);

        // r0 never forwards, unused operand never matches
        step(1, 9, 1, 0, 0, 0, 2'b00, 0);
        step(1, 0, 1, 0, 0, 0, 2'b00, 0);
        step(1, 0, 0, 0, 0, 9, 2'b01, 0);
        chk("r0_sel0", d_sel[0], 0);
        chk("unused_sel1", d_sel[1], 0);
        chk("r0_stall", d_stall, 0);
        idle(2);

        // Flush on the would-be stall cycle
        step(1, 2, 1, 1, 0, 0, 2'b00, 0);
        step(1, 0, 0, 0, 2, 0, 2'b01, 1);
        chk("flush_stall", d_stall, 0);
        chk("flush_sel0", d_sel[0], 0);
        step(1, 0, 0, 0, 2, 0, 2'b01, 0);
        chk("flush_busy_after", d_busy, 0);
        chk("flush_sel0_after", d_sel[0], 0);
        idle(2);

        // Asynchronous reset in the middle of a load-use stall
        step(1, 4, 1, 1, 0, 0, 2'b00, 0);
        drive(1, 0, 0, 0, 4, 0, 2'b01, 0);
        #2;
        chk("arst_pre_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sel", fwd_sel, 0);
        @(negedge clk);
        compare();
        record();
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 2'b00, 0);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 4, 0, 2'b01, 0);
        chk("arst_after_sel0", d_sel[0], 0);
`ifdef FWD_HAZARD_STATS_EN
        chk("arst_stats_stall", stat_stall_cyc, 0);
        chk("arst_stats_fwd", stat_fwd_cnt, 0);
        chk("arst_stats_ld", stat_ld_hazards, 0);
`endif

        // Randomized traffic over a small register range to provoke matches
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
